// File: rtl/vga_speed_scene.sv
// vga_speed_scene: VGA timing generator with a bouncing square whose speed is
// set by two debounced push buttons (up / down, 1..MAX_SPEED pixels per frame).
// Optional feature macro: SPEED_BAR_EN adds a speed bar along the top rows.
module vga_speed_scene #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int TICK_DIV  = 2,
   parameter int DB_BITS   = 20,
   parameter int MAX_SPEED = 8,
   parameter int SQ_SIZE   = 16,
   parameter int RGB_W     = 3,
   parameter logic [RGB_W-1:0] SQ_COLOR = 3'b100,
   parameter logic [RGB_W-1:0] BG_COLOR = 3'b001,
   localparam int SW = $clog2(MAX_SPEED + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       push,
   output logic             hsync,
   output logic             vsync,
   output logic [RGB_W-1:0] rgb,
   output logic             video_on,
   output logic [9:0]       pixel_x,
   output logic [9:0]       pixel_y,
   output logic [SW-1:0]    speed
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int TW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [TW-1:0]      TICK_MAX = TW'(TICK_DIV - 1);
   localparam logic [9:0]         H_MAX    = 10'(H_TOTAL - 1);
   localparam logic [9:0]         V_MAX    = 10'(V_TOTAL - 1);
   localparam logic [9:0]         H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0]         V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0]         HS_BEG   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]         HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0]         VS_BEG   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]         VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [9:0]         X_LIM    = 10'(H_ACTIVE - SQ_SIZE);
   localparam logic [9:0]         Y_LIM    = 10'(V_ACTIVE - SQ_SIZE);
   localparam logic [9:0]         X_INIT   = 10'((H_ACTIVE - SQ_SIZE) / 2);
   localparam logic [9:0]         Y_INIT   = 10'((V_ACTIVE - SQ_SIZE) / 2);
   localparam logic [SW-1:0]      SPD_MAX  = SW'(MAX_SPEED);
   localparam logic [SW-1:0]      SPD_MIN  = SW'(1);
   localparam logic [DB_BITS-1:0] DB_FULL  = {DB_BITS{1'b1}};

   // One axis of motion: returns {new_dir, new_pos}; dir 1 means increasing.
   // Sums are 11 bits wide so pos+speed near the far wall cannot wrap.
   function automatic logic [10:0] step_axis(input logic [9:0]    pos,
                                             input logic          dir_pos,
                                             input logic [SW-1:0] spd,
                                             input logic [9:0]    lim);
      logic [9:0]  spd_w;
      logic [10:0] sum;
      spd_w = 10'(spd);
      sum   = {1'b0, pos} + {1'b0, spd_w};
      if (dir_pos) begin
         if (sum > {1'b0, lim}) step_axis = {1'b0, lim};
         else                   step_axis = {1'b1, sum[9:0]};
      end else begin
         if (pos < spd_w) step_axis = {1'b1, 10'd0};
         else             step_axis = {1'b0, pos - spd_w};
      end
   endfunction

   logic [TW-1:0]      r_tick_cnt;
   logic [9:0]         r_h_cnt, r_v_cnt;
   logic [1:0]         r_sync1, r_sync2, r_db, r_db_d;
   logic [DB_BITS-1:0] r_db_cnt [2];
   logic [SW-1:0]      r_speed;
   logic [9:0]         r_sq_x, r_sq_y;
   logic               r_dir_x, r_dir_y;
   logic [RGB_W-1:0]   r_rgb;

   logic               w_tick, w_frame_tick, w_video_on, w_up_p, w_dn_p, w_in_sq;
   logic [10:0]        w_step_x, w_step_y, w_px, w_py, w_sq_x_end, w_sq_y_end;
   logic [RGB_W-1:0]   w_color;

   assign w_tick       = (r_tick_cnt == TICK_MAX);
   assign w_frame_tick = w_tick && (r_h_cnt == 10'd0) && (r_v_cnt == V_ACT);
   assign w_video_on   = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);

   // Pixel-rate divider: w_tick is high one clk in every TICK_DIV.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        r_tick_cnt <= '0;
      else if (w_tick) r_tick_cnt <= '0;
      else             r_tick_cnt <= r_tick_cnt + 1'b1;
   end

   // Raster counters: h wraps every line, v advances on each h wrap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (w_tick) begin
         if (r_h_cnt == H_MAX) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_MAX) ? 10'd0 : r_v_cnt + 10'd1;
         end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
         end
      end
   end

   assign hsync = !((r_h_cnt >= HS_BEG) && (r_h_cnt <= HS_END));
   assign vsync = !((r_v_cnt >= VS_BEG) && (r_v_cnt <= VS_END));

   // Button conditioning: 2-FF synchroniser, then the debounced level only
   // follows after 2^DB_BITS consecutive samples disagreeing with it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_db    <= '0;
         r_db_d  <= '0;
         for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
      end else begin
         r_sync1 <= push;
         r_sync2 <= r_sync1;
         r_db_d  <= r_db;
         for (int i = 0; i < 2; i++) begin
            if (r_sync2[i] != r_db[i]) begin
               if (r_db_cnt[i] == DB_FULL) begin
                  r_db[i]     <= r_sync2[i];
                  r_db_cnt[i] <= '0;
               end else begin
                  r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
               end
            end else begin
               r_db_cnt[i] <= '0;
            end
         end
      end
   end

   assign w_up_p = r_db[0] & ~r_db_d[0];
   assign w_dn_p = r_db[1] & ~r_db_d[1];

   // Speed register: saturating step up/down; simultaneous presses cancel.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_speed <= SPD_MIN;
      else if (w_up_p && !w_dn_p && (r_speed != SPD_MAX))
         r_speed <= r_speed + 1'b1;
      else if (w_dn_p && !w_up_p && (r_speed != SPD_MIN))
         r_speed <= r_speed - 1'b1;
   end

   assign w_step_x = step_axis(r_sq_x, r_dir_x, r_speed, X_LIM);
   assign w_step_y = step_axis(r_sq_y, r_dir_y, r_speed, Y_LIM);

   // Square motion: one step per frame tick, bouncing off all four walls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sq_x  <= X_INIT;
         r_sq_y  <= Y_INIT;
         r_dir_x <= 1'b1;
         r_dir_y <= 1'b1;
      end else if (w_frame_tick) begin
         r_sq_x  <= w_step_x[9:0];
         r_dir_x <= w_step_x[10];
         r_sq_y  <= w_step_y[9:0];
         r_dir_y <= w_step_y[10];
      end
   end

   assign w_px       = {1'b0, r_h_cnt};
   assign w_py       = {1'b0, r_v_cnt};
   assign w_sq_x_end = {1'b0, r_sq_x} + 11'(SQ_SIZE);
   assign w_sq_y_end = {1'b0, r_sq_y} + 11'(SQ_SIZE);
   assign w_in_sq    = (r_h_cnt >= r_sq_x) && (w_px < w_sq_x_end) &&
                       (r_v_cnt >= r_sq_y) && (w_py < w_sq_y_end);

`ifdef SPEED_BAR_EN
   logic [10:0] w_bar_len;
   assign w_bar_len = 11'({r_speed, 4'b0000});
`endif

   // Pixel colour decode: blanking, then bar (if built), square, background.
   // NOTE: w_color gets a default first so no path through the block infers a latch.
   always_comb begin
      w_color = '0;
      if (w_video_on) begin
         w_color = w_in_sq ? SQ_COLOR : BG_COLOR;
`ifdef SPEED_BAR_EN
         if ((r_v_cnt < 10'd8) && (w_px < w_bar_len)) w_color = ~BG_COLOR;
`endif
      end
   end

   // Colour output register, one clk behind the counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_rgb <= '0;
      else      r_rgb <= w_color;
   end

   assign rgb      = r_rgb;
   assign video_on = w_video_on;
   assign pixel_x  = r_h_cnt;
   assign pixel_y  = r_v_cnt;
   assign speed    = r_speed;

endmodule

// File: tb/tb_vga_speed_scene.sv
// tb_vga_speed_scene: scoreboard bench for vga_speed_scene. Stimulus pushes
// expected pixels / sync pulses / speed steps into queues; monitors pop and
// compare as the DUT presents them. The screen geometry is scaled down
// (64x24 active, 72x28 total, 4-pixel square) so multi-frame bounces stay short;
// every expected number below is derived from these values.
module tb_vga_speed_scene;

   localparam int HA = 64, HF = 2, HS = 4, HB = 2;
   localparam int VA = 24, VF = 1, VS = 2, VB = 1;
   localparam int TD = 2, SQ = 4, SW = 4;
   localparam int C_SQ = 4, C_BG = 1, C_BAR = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [1:0]    push = 2'b00;
   logic          hsync, vsync, video_on;
   logic [2:0]    rgb;
   logic [9:0]    pixel_x, pixel_y;
   logic [SW-1:0] speed;

   always #5 clk = ~clk;

   vga_speed_scene #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .TICK_DIV(TD), .DB_BITS(2), .MAX_SPEED(8), .SQ_SIZE(SQ),
      .RGB_W(3), .SQ_COLOR(3'b100), .BG_COLOR(3'b001)
   ) dut (
      .clk(clk), .rst(rst), .push(push),
      .hsync(hsync), .vsync(vsync), .rgb(rgb), .video_on(video_on),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .speed(speed)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, req);
   endtask

   typedef struct { int x; int y; int c; string name; } pix_exp_t;
   typedef struct { int start; int width; int period; } sync_exp_t;

   pix_exp_t  pix_q[$];
   sync_exp_t hs_q[$];
   sync_exp_t vs_q[$];
   int        spd_q[$];
   logic      mon_en = 1'b0;
   int        exp_spd = 1;
   int        clk_n = 0;

   // Square positions after frame ticks 1..10 at speed 4, starting at (30,10).
   int tx [10] = '{34, 38, 42, 46, 50, 54, 58, 60, 56, 52};
   int ty [10] = '{14, 18, 20, 16, 12,  8,  4,  0,  0,  4};

   always @(posedge clk) clk_n++;

   function automatic int exp_color(input int px, input int py, input int sx,
                                    input int sy, input int spd);
      if (px >= HA || py >= VA) return 0;
`ifdef SPEED_BAR_EN
      if (py < 8 && px < spd * 16) return C_BAR;
`else
      if (spd < 0) return 0;
`endif
      if (px >= sx && px < sx + SQ && py >= sy && py < sy + SQ) return C_SQ;
      return C_BG;
   endfunction

   task automatic push_pix(input int x, input int y, input int c, input string tag);
      pix_exp_t e;
      e.x = x; e.y = y; e.c = c;
      e.name = $sformatf("%s_rgb_%0d_%0d", tag, x, y);
      pix_q.push_back(e);
   endtask

   // Probe the square's corners and the pixels just outside it.
   task automatic push_square(input int sx, input int sy, input int spd);
      string tag;
      tag = $sformatf("sq%0d_%0d", sx, sy);
      push_pix(sx, sy, exp_color(sx, sy, sx, sy, spd), tag);
      push_pix(sx + SQ - 1, sy + SQ - 1, exp_color(sx + SQ - 1, sy + SQ - 1, sx, sy, spd), tag);
      push_pix(sx + SQ, sy, exp_color(sx + SQ, sy, sx, sy, spd), tag);
      push_pix(sx, sy + SQ, exp_color(sx, sy + SQ, sx, sy, spd), tag);
      if (sx > 0) push_pix(sx - 1, sy, exp_color(sx - 1, sy, sx, sy, spd), tag);
      if (sy > 0) push_pix(sx, sy - 1, exp_color(sx, sy - 1, sx, sy, spd), tag);
   endtask

   // Pixel monitor: rgb lags the counters by one clk, so compare on the
   // second negedge a coordinate is held.
   int prev_px = -1, prev_py = -1;
   always @(negedge clk) begin
      if (mon_en && rst && int'(pixel_x) == prev_px && int'(pixel_y) == prev_py) begin
         for (int i = pix_q.size() - 1; i >= 0; i--) begin
            if (pix_q[i].x == prev_px && pix_q[i].y == prev_py) begin
               check(pix_q[i].name, int'(rgb), pix_q[i].c);
               pix_q.delete(i);
            end
         end
      end
      prev_px = int'(pixel_x);
      prev_py = int'(pixel_y);
   end

   // Sync monitors: measure each low pulse (start coordinate, width, period).
   logic hs_prev = 1'b1, vs_prev = 1'b1;
   int   hs_fall = -1, hs_start = 0, hs_per = 0;
   int   vs_fall = -1, vs_start = 0, vs_per = 0;
   always @(negedge clk) begin
      sync_exp_t e;
      if (mon_en && rst) begin
         if (hs_prev && !hsync) begin
            hs_per = (hs_fall >= 0) ? clk_n - hs_fall : 0;
            hs_fall = clk_n; hs_start = int'(pixel_x);
         end
         if (!hs_prev && hsync && hs_q.size() > 0) begin
            e = hs_q.pop_front();
            check("hsync_start_x", hs_start, e.start);
            check("hsync_width_clks", clk_n - hs_fall, e.width);
            if (e.period != 0) check("hsync_period_clks", hs_per, e.period);
         end
         if (vs_prev && !vsync) begin
            vs_per = (vs_fall >= 0) ? clk_n - vs_fall : 0;
            vs_fall = clk_n; vs_start = int'(pixel_y);
         end
         if (!vs_prev && vsync && vs_q.size() > 0) begin
            e = vs_q.pop_front();
            check("vsync_start_line", vs_start, e.start);
            check("vsync_width_clks", clk_n - vs_fall, e.width);
            if (e.period != 0) check("vsync_period_clks", vs_per, e.period);
         end
      end
      hs_prev = hsync;
      vs_prev = vsync;
   end

   // Speed monitor: every change of speed must match the next queued step.
   logic [SW-1:0] spd_prev = '0;
   always @(negedge clk) begin
      if (mon_en && speed != spd_prev) begin
         if (spd_q.size() > 0) check("speed_step", int'(speed), spd_q.pop_front());
         else check("speed_unexpected_change", int'(speed), int'(spd_prev));
      end
      spd_prev = speed;
   end

   task automatic press(input logic [1:0] b);
      @(negedge clk) push = b;
      repeat (10) @(negedge clk);
      push = 2'b00;
      repeat (10) @(negedge clk);
   endtask

   task automatic press_up();
      if (exp_spd < 8) begin exp_spd++; spd_q.push_back(exp_spd); end
      press(2'b01);
   endtask

   task automatic press_dn();
      if (exp_spd > 1) begin exp_spd--; spd_q.push_back(exp_spd); end
      press(2'b10);
   endtask

   task automatic wait_xy(input int x, input int y, input string name);
      int n = 0;
      while (!(int'(pixel_x) == x && int'(pixel_y) == y) && n < 6000) begin
         @(negedge clk); n++;
      end
      check(name, int'(n < 6000), 1);
   endtask

   // Return on the first line after the start of the next vertical blank.
   task automatic wait_vblank();
      int n = 0;
      while (int'(pixel_y) >= VA && n < 6000) begin @(negedge clk); n++; end
      while (int'(pixel_y) != VA + 1 && n < 12000) begin @(negedge clk); n++; end
      check("vblank_reached", int'(n < 12000), 1);
   endtask

   initial begin
      sync_exp_t s;
      int n;
      // ---- 1: reset state and raster timing
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_rgb", int'(rgb), 0);
      check("rst_hsync", int'(hsync), 1);
      check("rst_vsync", int'(vsync), 1);
      check("rst_speed", int'(speed), 1);
      check("rst_pixel_x", int'(pixel_x), 0);
      check("rst_pixel_y", int'(pixel_y), 0);
      mon_en = 1'b1;
      s.start = HA + HF; s.width = HS * TD;
      s.period = 0;                     hs_q.push_back(s);
      s.period = (HA + HF + HS + HB) * TD; hs_q.push_back(s); hs_q.push_back(s);
      s.start = VA + VF; s.width = VS * (HA + HF + HS + HB) * TD;
      s.period = 0;                     vs_q.push_back(s);
      s.period = (VA + VF + VS + VB) * (HA + HF + HS + HB) * TD; vs_q.push_back(s);
      push_pix(31, 11, C_SQ, "f0");
      push_pix(0, 23, C_BG, "f0");
      push_pix(66, 10, 0, "f0");
      push_square(30, 10, 1);
      @(negedge clk) rst = 1'b1;
      n = 0;
      while (vs_q.size() > 0 && n < 10000) begin @(negedge clk); n++; end
      check("vsync_pulses_seen", vs_q.size(), 0);
      check("hsync_pulses_seen", hs_q.size(), 0);
      check("frame0_pixels_seen", pix_q.size(), 0);

      // ---- 2: clean presses, saturation both ways
      repeat (3) press_up();
      check("speed_after_3_up", int'(speed), 4);
      repeat (6) press_up();
      check("speed_sat_max", int'(speed), 8);
      repeat (9) press_dn();
      check("speed_sat_min", int'(speed), 1);

      // ---- 3: glitches and simultaneous presses leave speed alone
      press_up();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk) push = 2'b01;
         repeat (2) @(negedge clk);
         push = 2'b00;
         repeat (6) @(negedge clk);
      end
      repeat (10) @(negedge clk);
      check("speed_after_glitches", int'(speed), 2);
      press(2'b11);
      check("speed_after_both", int'(speed), 2);

      // ---- 6: asynchronous reset mid-line
      wait_xy(40, 5, "reached_h40_v5");
      check("pre_reset_rgb_nonzero", int'(rgb != 3'b000), 1);
      spd_q.push_back(1);
      exp_spd = 1;
      rst = 1'b0;
      #1;
      check("midrst_rgb", int'(rgb), 0);
      check("midrst_hsync", int'(hsync), 1);
      check("midrst_vsync", int'(vsync), 1);
      check("midrst_speed", int'(speed), 1);
      check("midrst_pixel_x", int'(pixel_x), 0);
      check("midrst_pixel_y", int'(pixel_y), 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      push_square(30, 10, 1);

      // ---- 4: speed 4, bounce off right and bottom/top walls
      repeat (3) press_up();
      check("speed_set_4", int'(speed), 4);
      for (int f = 0; f < 10; f++) begin
         wait_vblank();
         push_square(tx[f], ty[f], 4);
      end

      // ---- 5: speed change applies at the next frame tick; bar edge pixels
      press_dn();
      check("speed_set_3", int'(speed), 3);
      wait_vblank();
      push_square(49, 7, 3);
      push_pix(47, 0, exp_color(47, 0, 49, 7, 3), "bar");
      push_pix(48, 0, exp_color(48, 0, 49, 7, 3), "bar");
      wait_vblank();
      check("all_pixels_seen", pix_q.size(), 0);
      check("all_speed_steps_seen", spd_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not complete, %0d/%0d so far", n_pass, n_checks);
      $fatal(1);
   end

endmodule
